// File: rtl/ritc_phase_scan_pkg.sv
// Shared types and widths for the RITC phase scan sequencer.
package ritc_phase_scan_pkg;

  localparam int unsigned STEP_W   = 10;
  localparam int unsigned SCALER_W = 7;
  localparam int unsigned TIMER_W  = 12;

  typedef enum logic [1:0] {
    SCAN_BIT  = 2'd0,
    SCAN_CLK  = 2'd1,
    SCAN_VCDL = 2'd2,
    SCAN_RSVD = 2'd3
  } scan_type_t;

  typedef enum logic [3:0] {
    IDLE,
    SELECT,
    SETTLE,
    SCAN,
    WAIT_DONE,
    EVAL,
    PS_REQ,
    PS_WAIT,
    RET_REQ,
    RET_WAIT,
    FINISH
  } state_t;

  function automatic logic [SCALER_W-1:0] pick_scaler(
    input scan_type_t          t,
    input logic [SCALER_W-1:0] bit_s,
    input logic [SCALER_W-1:0] clk_s,
    input logic [SCALER_W-1:0] vcdl_s
  );
    case (t)
      SCAN_CLK:  return clk_s;
      SCAN_VCDL: return vcdl_s;
      default:   return bit_s;
    endcase
  endfunction

endpackage

// File: rtl/ritc_phase_scan_timer.sv
// Loadable down-counter; expired is high whenever the count has reached zero.
module ritc_phase_scan_timer #(
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/ritc_phase_scan_sequencer.sv
// Automated MMCM phase sweep over the RITC scanner, reporting the first level edge.
// Optional: define PHASE_SCAN_RETURN_EN to step the phase back to its start before done_o.
module ritc_phase_scan_sequencer
  import ritc_phase_scan_pkg::*;
#(
  parameter int unsigned MAX_STEPS  = 1023,
  parameter int unsigned THRESH     = 64,
  parameter int unsigned SEL_SETTLE = 8,
  parameter int unsigned TIMEOUT    = 4095
) (
  input  logic                user_clk_i,
  input  logic                user_rst_i,
  input  logic                start_i,
  input  logic [7:0]          select_i,
  input  logic [1:0]          scan_type_i,
  output logic [7:0]          sel_o,
  output logic                sel_wr_o,
  output logic                scan_o,
  input  logic                scan_done_i,
  input  logic [SCALER_W-1:0] bit_scaler_i,
  input  logic [SCALER_W-1:0] clk_scaler_i,
  input  logic [SCALER_W-1:0] vcdl_scaler_i,
  output logic                ps_en_o,
  output logic                ps_incdec_o,
  input  logic                ps_done_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                edge_found_o,
  output logic                edge_polarity_o,
  output logic [STEP_W-1:0]   edge_step_o,
  output logic                error_o,
  output logic [SCALER_W-1:0] last_scaler_o
);

  // Timer expires on the last cycle of the wait, hence the minus one.
  localparam logic [TIMER_W-1:0]  SETTLE_LOAD  = TIMER_W'(SEL_SETTLE - 1);
  localparam logic [TIMER_W-1:0]  TIMEOUT_LOAD = TIMER_W'(TIMEOUT - 1);
  localparam logic [STEP_W-1:0]   STEP_MAX     = STEP_W'(MAX_STEPS);
  localparam logic [SCALER_W:0]   THRESH_V     = (SCALER_W+1)'(THRESH);

  state_t               state_q, state_d, end_state;
  scan_type_t           type_q, type_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic                 prev_level_q, prev_level_d;
  logic                 armed_q, armed_d;
  logic                 level;

  logic [7:0]           sel_d;
  logic                 sel_wr_d, scan_d, ps_en_d, ps_incdec_d, busy_d, done_d;
  logic                 edge_found_d, edge_polarity_d, error_d;
  logic [STEP_W-1:0]    edge_step_d;
  logic [SCALER_W-1:0]  last_scaler_d;

  logic                 timer_load, timer_expired;
  logic [TIMER_W-1:0]   timer_val;

  ritc_phase_scan_timer #(.W(TIMER_W)) u_timer (
    .clk      (user_clk_i),
    .rst      (user_rst_i),
    .load     (timer_load),
    .load_val (timer_val),
    .expired  (timer_expired)
  );

  assign level = ({1'b0, last_scaler_o} >= THRESH_V);

`ifdef PHASE_SCAN_RETURN_EN
  assign end_state = (step_q != '0) ? RET_REQ : FINISH;
`else
  assign end_state = FINISH;
`endif

  always_comb begin
    state_d         = state_q;
    type_d          = type_q;
    step_d          = step_q;
    prev_level_d    = prev_level_q;
    armed_d         = armed_q;
    sel_d           = sel_o;
    sel_wr_d        = 1'b0;
    scan_d          = 1'b0;
    ps_en_d         = 1'b0;
    ps_incdec_d     = ps_incdec_o;
    busy_d          = busy_o;
    done_d          = 1'b0;
    edge_found_d    = edge_found_o;
    edge_polarity_d = edge_polarity_o;
    edge_step_d     = edge_step_o;
    error_d         = error_o;
    last_scaler_d   = last_scaler_o;
    timer_load      = 1'b0;
    timer_val       = TIMEOUT_LOAD;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          sel_d           = select_i;
          type_d          = scan_type_t'(scan_type_i);
          step_d          = '0;
          edge_found_d    = 1'b0;
          edge_polarity_d = 1'b0;
          edge_step_d     = '0;
          error_d         = 1'b0;
          busy_d          = 1'b1;
          state_d         = SELECT;
        end
      end
      SELECT: begin
        sel_wr_d   = 1'b1;
        timer_load = 1'b1;
        timer_val  = SETTLE_LOAD;
        state_d    = SETTLE;
      end
      SETTLE: begin
        if (timer_expired) state_d = SCAN;
      end
      SCAN: begin
        scan_d     = 1'b1;
        timer_load = 1'b1;
        armed_d    = 1'b0;
        state_d    = WAIT_DONE;
      end
      WAIT_DONE: begin
        // scan_done_i is still stale during the first cycle after scan_o.
        armed_d = 1'b1;
        if (armed_q && scan_done_i) begin
          last_scaler_d = pick_scaler(type_q, bit_scaler_i, clk_scaler_i, vcdl_scaler_i);
          state_d       = EVAL;
        end else if (timer_expired) begin
          error_d = 1'b1;
          state_d = end_state;
        end
      end
      EVAL: begin
        if ((step_q != '0) && (level != prev_level_q)) begin
          edge_found_d    = 1'b1;
          edge_polarity_d = level;
          edge_step_d     = step_q;
          state_d         = end_state;
        end else begin
          if (step_q == '0) prev_level_d = level;
          state_d = (step_q >= STEP_MAX) ? end_state : PS_REQ;
        end
      end
      PS_REQ: begin
        ps_en_d     = 1'b1;
        ps_incdec_d = 1'b1;
        timer_load  = 1'b1;
        state_d     = PS_WAIT;
      end
      PS_WAIT: begin
        if (ps_done_i) begin
          step_d  = step_q + STEP_W'(1);
          state_d = SCAN;
        end else if (timer_expired) begin
          error_d = 1'b1;
          state_d = end_state;
        end
      end
`ifdef PHASE_SCAN_RETURN_EN
      // step_q doubles as the count of decrements still owed.
      RET_REQ: begin
        if (step_q == '0) begin
          state_d = FINISH;
        end else begin
          ps_en_d     = 1'b1;
          ps_incdec_d = 1'b0;
          timer_load  = 1'b1;
          state_d     = RET_WAIT;
        end
      end
      RET_WAIT: begin
        if (ps_done_i) begin
          step_d  = step_q - STEP_W'(1);
          state_d = RET_REQ;
        end else if (timer_expired) begin
          error_d = 1'b1;
          state_d = FINISH;
        end
      end
`endif
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge user_clk_i) begin
    if (user_rst_i) begin
      state_q         <= IDLE;
      type_q          <= SCAN_BIT;
      step_q          <= '0;
      prev_level_q    <= 1'b0;
      armed_q         <= 1'b0;
      sel_o           <= '0;
      sel_wr_o        <= 1'b0;
      scan_o          <= 1'b0;
      ps_en_o         <= 1'b0;
      ps_incdec_o     <= 1'b0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      edge_found_o    <= 1'b0;
      edge_polarity_o <= 1'b0;
      edge_step_o     <= '0;
      error_o         <= 1'b0;
      last_scaler_o   <= '0;
    end else begin
      state_q         <= state_d;
      type_q          <= type_d;
      step_q          <= step_d;
      prev_level_q    <= prev_level_d;
      armed_q         <= armed_d;
      sel_o           <= sel_d;
      sel_wr_o        <= sel_wr_d;
      scan_o          <= scan_d;
      ps_en_o         <= ps_en_d;
      ps_incdec_o     <= ps_incdec_d;
      busy_o          <= busy_d;
      done_o          <= done_d;
      edge_found_o    <= edge_found_d;
      edge_polarity_o <= edge_polarity_d;
      edge_step_o     <= edge_step_d;
      error_o         <= error_d;
      last_scaler_o   <= last_scaler_d;
    end
  end

endmodule

// File: tb/tb_ritc_phase_scan_sequencer.sv
// Directed bench for ritc_phase_scan_sequencer with behavioural scanner and MMCM models.
module tb_ritc_phase_scan_sequencer;

  localparam int TIMEOUT = 60;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] select = 8'h00;
  logic [1:0] scan_type = 2'd0;
  logic       scan_done = 1'b0;
  logic [6:0] bit_s = '0, clk_s = '0, vcdl_s = '0;
  logic       ps_done = 1'b0;

  logic [7:0] sel_o;
  logic       sel_wr_o, scan_o, ps_en_o, ps_incdec_o, busy_o, done_o;
  logic       edge_found_o, edge_polarity_o, error_o;
  logic [9:0] edge_step_o;
  logic [6:0] last_scaler_o;

  ritc_phase_scan_sequencer #(
    .MAX_STEPS (40),
    .THRESH    (64),
    .SEL_SETTLE(8),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .user_clk_i     (clk),
    .user_rst_i     (rst),
    .start_i        (start),
    .select_i       (select),
    .scan_type_i    (scan_type),
    .sel_o          (sel_o),
    .sel_wr_o       (sel_wr_o),
    .scan_o         (scan_o),
    .scan_done_i    (scan_done),
    .bit_scaler_i   (bit_s),
    .clk_scaler_i   (clk_s),
    .vcdl_scaler_i  (vcdl_s),
    .ps_en_o        (ps_en_o),
    .ps_incdec_o    (ps_incdec_o),
    .ps_done_i      (ps_done),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .edge_found_o   (edge_found_o),
    .edge_polarity_o(edge_polarity_o),
    .edge_step_o    (edge_step_o),
    .error_o        (error_o),
    .last_scaler_o  (last_scaler_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Model configuration, written only by the stimulus block.
  logic [1:0] m_type = 2'd0;
  logic [6:0] m_lo = '0, m_hi = '0, m_oth = '0;
  int         m_edge = 1000;
  int         pos_base = 0;
  bit         scan_en = 1'b1;

  // Model state, written only by the model block.
  int pos = 0, inc_cnt = 0, dec_cnt = 0, selwr_cnt = 0, scan_cyc = 0;
  int ps_pend = 0, sc_pend = 0;
  bit sc_clear = 1'b0;

  always @(negedge clk) begin
    logic [6:0] v;
    ps_done = 1'b0;
    if (ps_pend != 0) begin
      ps_pend--;
      if (ps_pend == 0) ps_done = 1'b1;
    end
    if (ps_en_o) begin
      if (ps_incdec_o) begin inc_cnt++; pos++; end
      else begin dec_cnt++; pos--; end
      ps_pend = 2;
    end
    if (sel_wr_o) selwr_cnt++;
    if (sc_clear) begin
      scan_done = 1'b0;
      sc_clear  = 1'b0;
    end else if (sc_pend != 0) begin
      sc_pend--;
      if (sc_pend == 0) begin
        v      = ((pos - pos_base) >= m_edge) ? m_hi : m_lo;
        bit_s  = (m_type == 2'd0) ? v : m_oth;
        clk_s  = (m_type == 2'd1) ? v : m_oth;
        vcdl_s = (m_type == 2'd2) ? v : m_oth;
        scan_done = 1'b1;
      end
    end
    if (scan_o) begin
      sc_clear = 1'b1;
      sc_pend  = scan_en ? 4 : 0;
      scan_cyc = cyc;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (!done_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, done_o}, 32'd1);
  endtask

  task automatic setup(input logic [1:0] t, input logic [6:0] lo, input logic [6:0] hi,
                       input int e, input logic [6:0] oth);
    m_type = t; m_lo = lo; m_hi = hi; m_edge = e; m_oth = oth;
    pos_base = pos;
  endtask

  task automatic go(input logic [7:0] s, input logic [1:0] t);
    @(negedge clk);
    start = 1'b1; select = s; scan_type = t;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({sel_o, sel_wr_o, scan_o, ps_en_o, ps_incdec_o, busy_o, done_o,
                edge_found_o, edge_polarity_o, edge_step_o, error_o} | 33'(last_scaler_o));
  endfunction

  int inc0, dec0, sw0, n, exp_dec, exp_pos;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 32'd0);
    check("reset_last_scaler", 32'(last_scaler_o), 32'd0);
    rst = 1'b0;

    // 1: clk scaler edge at step 37, rising
    setup(2'd1, 7'd10, 7'd100, 37, 7'd127);
    inc0 = inc_cnt; dec0 = dec_cnt; sw0 = selwr_cnt;
    go(8'hA5, 2'd1);
    check("t1_busy", 32'(busy_o), 32'd1);
    wait_done(3000, "t1_done");
    check("t1_busy_clr", 32'(busy_o), 32'd0);
    check("t1_found", 32'(edge_found_o), 32'd1);
    check("t1_pol", 32'(edge_polarity_o), 32'd1);
    check("t1_step", 32'(edge_step_o), 32'd37);
    check("t1_inc", 32'(inc_cnt - inc0), 32'd37);
    check("t1_err", 32'(error_o), 32'd0);
    check("t1_sel", 32'(sel_o), 32'hA5);
    check("t1_selwr", 32'(selwr_cnt - sw0), 32'd1);
    check("t1_last", 32'(last_scaler_o), 32'd100);

    // 2: bit scaler fixed at 127 runs to MAX_STEPS; mid-sweep start ignored
    setup(2'd0, 7'd127, 7'd127, 1000, 7'd0);
    inc0 = inc_cnt; sw0 = selwr_cnt;
    go(8'h5A, 2'd0);
    repeat (20) @(negedge clk);
    start = 1'b1; select = 8'hFF; scan_type = 2'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done(3000, "t2_done");
    check("t2_found", 32'(edge_found_o), 32'd0);
    check("t2_step", 32'(edge_step_o), 32'd0);
    check("t2_inc", 32'(inc_cnt - inc0), 32'd40);
    check("t2_err", 32'(error_o), 32'd0);
    check("t2_selwr", 32'(selwr_cnt - sw0), 32'd1);
    check("t2_sel", 32'(sel_o), 32'h5A);

    // 3: scanner never answers, timeout
    scan_en = 1'b0;
    setup(2'd0, 7'd0, 7'd0, 1000, 7'd0);
    go(8'h11, 2'd0);
    wait_done(500, "t3_done");
    check("t3_latency", 32'(cyc - scan_cyc), 32'(TIMEOUT + 1));
    check("t3_err", 32'(error_o), 32'd1);
    check("t3_busy", 32'(busy_o), 32'd0);
    check("t3_found", 32'(edge_found_o), 32'd0);
    scan_en = 1'b1;

    // 4: threshold boundary on vcdl scaler
    setup(2'd2, 7'd63, 7'd64, 1, 7'd0);
    go(8'h22, 2'd2);
    wait_done(500, "t4a_done");
    check("t4a_found", 32'(edge_found_o), 32'd1);
    check("t4a_pol", 32'(edge_polarity_o), 32'd1);
    check("t4a_step", 32'(edge_step_o), 32'd1);
    check("t4a_err", 32'(error_o), 32'd0);
    setup(2'd2, 7'd64, 7'd63, 1, 7'd127);
    go(8'h23, 2'd3 ^ 2'd1);
    wait_done(500, "t4b_done");
    check("t4b_found", 32'(edge_found_o), 32'd1);
    check("t4b_pol", 32'(edge_polarity_o), 32'd0);
    check("t4b_step", 32'(edge_step_o), 32'd1);

    // 5: reset in PS_WAIT at step 5, start coincident with reset, restart
    setup(2'd0, 7'd10, 7'd10, 1000, 7'd127);
    inc0 = inc_cnt;
    go(8'h44, 2'd0);
    n = 0;
    while ((inc_cnt - inc0) != 6 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("t5_reach_step5", 32'(inc_cnt - inc0), 32'd6);
    rst = 1'b1;
    @(negedge clk);
    check("t5_reset_outs", all_outs(), 32'd0);
    start = 1'b1; select = 8'h77;
    @(negedge clk);
    check("t5_rst_wins", 32'(busy_o), 32'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("t5_idle", all_outs(), 32'd0);
    setup(2'd0, 7'd0, 7'd127, 2, 7'd0);
    inc0 = inc_cnt; sw0 = selwr_cnt;
    go(8'h3C, 2'd0);
    wait_done(1000, "t5_done");
    check("t5_selwr", 32'(selwr_cnt - sw0), 32'd1);
    check("t5_sel", 32'(sel_o), 32'h3C);
    check("t5_step", 32'(edge_step_o), 32'd2);
    check("t5_inc", 32'(inc_cnt - inc0), 32'd2);

    // 6: edge at step 20, optional phase return
`ifdef PHASE_SCAN_RETURN_EN
    exp_dec = 20; exp_pos = 0;
`else
    exp_dec = 0; exp_pos = 20;
`endif
    setup(2'd1, 7'd100, 7'd5, 20, 7'd100);
    inc0 = inc_cnt; dec0 = dec_cnt;
    go(8'h66, 2'd1);
    wait_done(3000, "t6_done");
    check("t6_step", 32'(edge_step_o), 32'd20);
    check("t6_pol", 32'(edge_polarity_o), 32'd0);
    check("t6_inc", 32'(inc_cnt - inc0), 32'd20);
    check("t6_dec", 32'(dec_cnt - dec0), 32'(exp_dec));
    check("t6_pos", 32'(pos - pos_base), 32'(exp_pos));
    check("t6_err", 32'(error_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
